dpram_byte_packer: RTL and testbench
====================================

// Module: dpram_byte_packer
// PURPOSE
//  Upstream fill stage for the 32-bit byte-enabled dual-port RAM.
//  - Accepts a valid/ready byte stream and packs bytes little-endian into 32-bit words.
//  - Drives one RAM port with per-byte write enables, starting at a programmed base address.
//  - Sustains 1 byte/clk and enforces a programmed word limit.
// PARAMETERS
//  AW   12   RAM word-address width; the address wraps modulo 2^AW
// PORTS
//  clk            in   1     single clock, rising edge
//  rst_b          in   1     asynchronous active-low reset
//  cfg_start      in   1     pulse: begin a transfer (sampled in IDLE only)
//  cfg_base_addr  in   AW    first RAM word address
//  cfg_len_words  in   AW+1  max words to write (0 = no writes)
//  s_valid        in   1     byte valid
//  s_ready        out  1     byte accepted when s_valid & s_ready
//  s_data         in   8     byte data
//  s_last         in   1     final byte of the transfer
//  ram_en         out  1     RAM port enable (write cycle)
//  ram_addr       out  AW    RAM word address
//  ram_din        out  32    packed word
//  ram_we         out  4     byte write enables
//  busy           out  1     high from the cycle after start until done
//  done           out  1     one-cycle completion pulse
//  err_len        out  1     sticky: limit hit before s_last; cleared by next accepted start
//  words_written  out  AW+1  words written in this transfer (partial words count)
// BEHAVIOUR
//  Reset: every output is 0 (s_ready=0, ram_*=0, busy=0, done=0, err_len=0,
//   words_written=0); FSM=IDLE; accumulator and byte lane=0.
//  FSM IDLE -> PACK -> DONE -> IDLE. All outputs are registered.
//  IDLE:
//   - cfg_start: latch base/len, clear err_len and words_written, lane=0.
//   - If len!=0, go to PACK (busy=1 next cycle). If len==0, go to DONE (no RAM write).
//  PACK:
//   - s_ready=1. An accepted byte goes to lane n (bits 8n+7:8n); n increments.
//   - On the byte that fills lane 3, or on any accepted byte with s_last, the next cycle has:
//       ram_en=1, ram_addr=current addr, ram_din=packed word (unfilled lanes 0),
//       ram_we = bit i set iff lane i filled (last at lane 1 -> 4'b0011).
//   - In the same edge: addr+1 (wrap 2^AW-1 -> 0), words_written+1, lane=0,
//     accumulator cleared. A byte can therefore be accepted every cycle with no bubble.
//   - s_last: go to DONE. The final write and done are asserted in the same cycle.
//   - Word written == len without s_last: set err_len, go to DONE, s_ready=0 from
//     that edge. Bytes still offered are not accepted.
//  DONE (1 cycle): done=1, busy=0, s_ready=0, then IDLE.
//   - cfg_start in PACK/DONE is ignored.
//  ram_en is a 1-cycle strobe per word; otherwise ram_en=0 and ram_we=0.
//   ram_addr and ram_din hold their last value.
//  s_valid with s_ready=0 is held off; no byte is lost or duplicated.
//  Reset mid-transfer: the write in flight is dropped and all state returns to reset values.
// TESTING
//  1. base=0x010, len=4, bytes 11 22 33 44 55 66 77 88 (last on 88), back-to-back
//     -> writes 0x44332211@0x010, 0x88776655@0x011, we=F each; done with 2nd write;
//     words_written=2; err_len=0.
//  2. base=0x020, len=4, bytes AA BB CC, last on CC
//     -> one write 0x00CCBBAA@0x020, we=4'b0111; done.
//  3. base=0xFFF, len=3, 12 bytes
//     -> writes at 0xFFF, 0x000, 0x001 (wrap).
//  4. len=1, 6 bytes offered, no last
//     -> one write; err_len=1; s_ready low after the 4th byte; done pulses; bytes 5-6 unaccepted.
//  5. Random s_valid gaps, plus cfg_start pulsed mid-PACK
//     -> data and addresses match the scoreboard; the start has no effect.
//     Also len=0 start -> done 1 cycle later, no ram_en.
//  6. rst_b low during PACK after 2 bytes
//     -> all outputs 0 asynchronously; the next transfer starts cleanly at lane 0.

Source files
------------

// File: rtl/dpram_byte_packer_if.sv
// Byte-stream and RAM-write bundle for the dual-port RAM fill stage.
// The master side produces bytes and observes the RAM port. The slave side
// (the packer) accepts bytes and drives the RAM write port.
interface dpram_byte_packer_if #(
  parameter int AW = 12
) ();

  // Byte stream (valid/ready)
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          s_last;

  // RAM write port
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [3:0]    ram_we;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, ram_en, ram_addr, ram_din, ram_we
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, ram_en, ram_addr, ram_din, ram_we
  );

endinterface

// File: rtl/dpram_byte_packer.sv
// Packs a valid/ready byte stream little-endian into 32-bit words and writes
// them to a byte-enabled RAM port from a programmed base address. A word is
// flushed when lane 3 fills or on s_last, and the transfer stops early once
// the programmed word limit is reached. Every output is registered.
module dpram_byte_packer #(
  parameter int AW = 12
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 cfg_start,
  input  logic [AW-1:0]        cfg_base_addr,
  input  logic [AW:0]          cfg_len_words,
  dpram_byte_packer_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len,
  output logic [AW:0]          words_written
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   WORDS_ONE = {{AW{1'b0}}, 1'b1};

  // FSM state
  state_e        state_q, state_d;

  // Transfer context
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   len_q, len_d;
  logic [1:0]    lane_q, lane_d;
  // Only lanes 0..2 are ever held; the lane-3 byte goes straight into the flush word.
  logic [23:0]   acc_q, acc_d;

  // Registered outputs
  logic          s_ready_q, s_ready_d;
  logic          ram_en_q, ram_en_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_din_q, ram_din_d;
  logic [3:0]    ram_we_q, ram_we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_len_q, err_len_d;
  logic [AW:0]   words_q, words_d;

  // Datapath helpers
  logic          accept;
  logic          flush;
  logic          limit_hit;
  logic [31:0]   word_now;
  logic [3:0]    we_now;
  logic [AW:0]   words_inc;

  // Decode the current byte: acceptance, merged word and the flush conditions.
  always_comb begin
    accept    = (state_q == ST_PACK) && s_ready_q && bus.s_valid;
    word_now  = {8'h00, acc_q} | ({24'h000000, bus.s_data} << {lane_q, 3'b000});
    unique case (lane_q)
      2'd0:    we_now = 4'b0001;
      2'd1:    we_now = 4'b0011;
      2'd2:    we_now = 4'b0111;
      default: we_now = 4'b1111;
    endcase
    words_inc = words_q + WORDS_ONE;
    flush     = accept && ((lane_q == 2'd3) || bus.s_last);
    // s_last wins over the limit: a final word that also meets the limit is not an error.
    limit_hit = flush && !bus.s_last && (words_inc == len_q);
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> PACK (or straight to DONE for len 0) -> DONE -> IDLE.
  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_len_words == '0) ? ST_DONE : ST_PACK;
        end
      end
      ST_PACK: begin
        if ((accept && bus.s_last) || limit_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; status flags follow the next state so they
  // line up with it in the registered outputs.
  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    ram_en_d   = 1'b0;
    ram_we_d   = 4'b0000;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    err_len_d  = err_len_q;
    words_d    = words_q;
    s_ready_d  = (state_d == ST_PACK);
    busy_d     = (state_d == ST_PACK);
    done_d     = (state_d == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          addr_d    = cfg_base_addr;
          len_d     = cfg_len_words;
          lane_d    = 2'd0;
          acc_d     = '0;
          err_len_d = 1'b0;
          words_d   = '0;
        end
      end
      ST_PACK: begin
        if (flush) begin
          ram_en_d   = 1'b1;
          ram_addr_d = addr_q;
          ram_din_d  = word_now;
          ram_we_d   = we_now;
          addr_d     = addr_q + ADDR_ONE;
          words_d    = words_inc;
          lane_d     = 2'd0;
          acc_d      = '0;
          if (limit_hit) begin
            err_len_d = 1'b1;
          end
        end else if (accept) begin
          acc_d  = word_now[23:0];
          lane_d = lane_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Context and output registers; reset drops any write in flight.
  // NOTE: every flop here, including the accumulator, is reset so a reset mid-transfer
  // leaves no stale bytes for the next transfer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      addr_q     <= '0;
      len_q      <= '0;
      lane_q     <= 2'd0;
      acc_q      <= '0;
      s_ready_q  <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      words_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      s_ready_q  <= s_ready_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
      words_q    <= words_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_we    = ram_we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_len       = err_len_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_dpram_byte_packer.sv
// Self-checking bench for dpram_byte_packer: a table of directed transfers,
// followed by hand-written sequences for len=0, gapped input with a stray
// start, and asynchronous reset in the middle of a transfer.
module tb_dpram_byte_packer;

  localparam int AW = 12;

  logic          clk;
  logic          rst_b;
  logic          cfg_start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW:0]   cfg_len_words;
  logic          busy;
  logic          done;
  logic          err_len;
  logic [AW:0]   words_written;

  dpram_byte_packer_if #(.AW(AW)) bus ();

  dpram_byte_packer #(.AW(AW)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_len_words (cfg_len_words),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .err_len       (err_len),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed transfer and everything expected from it.
  // Byte i of data is data[8i+7:8i]; write k is a[12k+11:12k], d[32k+31:32k], we[4k+3:4k].
  typedef struct packed {
    logic [11:0] base;
    logic [12:0] len;
    int          nbytes;
    int          last_idx;   // -1: no byte carries s_last
    logic [95:0] data;
    int          nw;
    logic [35:0] a;
    logic [95:0] d;
    logic [11:0] we;
    logic        err;
    logic [12:0] ww;
    int          nacc;
  } vec_t;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  we;
  } wr_t;

  wr_t cap[$];
  int  done_cnt;
  int  done_w;
  int  we_idle_bad;
  int  n_pass;
  int  n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Observe the RAM port and done away from the active edge.
  always @(negedge clk) begin
    if (bus.ram_en === 1'b1) cap.push_back({bus.ram_addr, bus.ram_din, bus.ram_we});
    if (done === 1'b1) begin
      done_cnt++;
      if (bus.ram_en === 1'b1) done_w++;
    end
    if (bus.ram_en === 1'b0 && bus.ram_we !== 4'b0000) we_idle_bad++;
  end

  task automatic clear_obs();
    cap.delete();
    done_cnt    = 0;
    done_w      = 0;
    we_idle_bad = 0;
  endtask

  // Called at a negedge; pulses cfg_start for one edge and returns at the next negedge.
  task automatic start_xfer(input logic [AW-1:0] base, input logic [AW:0] len);
    cfg_base_addr = base;
    cfg_len_words = len;
    cfg_start     = 1'b1;
    @(negedge clk);
    cfg_start     = 1'b0;
  endtask

  // Called at a negedge; offers one byte for up to max_wait edges.
  task automatic push_byte(input logic [7:0] d, input logic last, input int max_wait,
                           output bit ok);
    ok          = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int t = 0; t < max_wait; t++) begin
      if (bus.s_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    bit          ok;
    int          nacc;
    logic [31:0] exp_w[3];
    logic [7:0]  b;

    n_pass        = 0;
    n_total       = 0;
    rst_b         = 1'b0;
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    cfg_len_words = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    bus.s_last    = 1'b0;
    clear_obs();

    vecs[0] = '{base: 12'h010, len: 13'd4, nbytes: 8, last_idx: 7,
                data: 96'h0000_0000_8877_6655_4433_2211, nw: 2,
                a: 36'h000_011_010, d: 96'h0000_0000_8877_6655_4433_2211,
                we: 12'h0FF, err: 1'b0, ww: 13'd2, nacc: 8};
    vecs[1] = '{base: 12'h020, len: 13'd4, nbytes: 3, last_idx: 2,
                data: 96'h00CC_BBAA, nw: 1,
                a: 36'h000_000_020, d: 96'h00CC_BBAA,
                we: 12'h007, err: 1'b0, ww: 13'd1, nacc: 3};
    vecs[2] = '{base: 12'hFFF, len: 13'd3, nbytes: 12, last_idx: 11,
                data: 96'h0C0B_0A09_0807_0605_0403_0201, nw: 3,
                a: 36'h001_000_FFF, d: 96'h0C0B_0A09_0807_0605_0403_0201,
                we: 12'hFFF, err: 1'b0, ww: 13'd3, nacc: 12};
    vecs[3] = '{base: 12'h100, len: 13'd1, nbytes: 6, last_idx: -1,
                data: 96'h0605_0403_0201, nw: 1,
                a: 36'h000_000_100, d: 96'h0403_0201,
                we: 12'h00F, err: 1'b1, ww: 13'd1, nacc: 4};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", {63'd0, bus.s_ready}, 64'd0);
    check("rst_ram_en_we", {59'd0, bus.ram_en, bus.ram_we}, 64'd0);
    check("rst_ram_addr_din", {20'd0, bus.ram_addr, bus.ram_din}, 64'd0);
    check("rst_status", {48'd0, busy, done, err_len, words_written}, 64'd0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Directed transfers from the table
    for (int v = 0; v < 4; v++) begin
      clear_obs();
      nacc = 0;
      start_xfer(vecs[v].base, vecs[v].len);
      check($sformatf("v%0d_busy_after_start", v), {63'd0, busy}, 64'd1);
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        push_byte(vecs[v].data[8*i +: 8], (i == vecs[v].last_idx), 8, ok);
        if (ok) nacc++;
      end
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_bytes_accepted", v), 64'(nacc), 64'(vecs[v].nacc));
      check($sformatf("v%0d_num_writes", v), 64'(cap.size()), 64'(vecs[v].nw));
      for (int k = 0; k < vecs[v].nw && k < cap.size(); k++) begin
        check($sformatf("v%0d_w%0d_addr", v, k), 64'(cap[k].a), 64'(vecs[v].a[12*k +: 12]));
        check($sformatf("v%0d_w%0d_din", v, k), 64'(cap[k].d), 64'(vecs[v].d[32*k +: 32]));
        check($sformatf("v%0d_w%0d_we", v, k), 64'(cap[k].we), 64'(vecs[v].we[4*k +: 4]));
      end
      check($sformatf("v%0d_done_pulses", v), 64'(done_cnt), 64'd1);
      check($sformatf("v%0d_done_with_write", v), 64'(done_w), 64'd1);
      check($sformatf("v%0d_err_len", v), {63'd0, err_len}, {63'd0, vecs[v].err});
      check($sformatf("v%0d_words_written", v), 64'(words_written), 64'(vecs[v].ww));
      check($sformatf("v%0d_idle_after", v), {62'd0, busy, bus.s_ready}, 64'd0);
      check($sformatf("v%0d_we_idle_zero", v), 64'(we_idle_bad), 64'd0);
    end

    // len=0: done the cycle after start, no RAM write, no busy
    clear_obs();
    start_xfer(12'h200, 13'd0);
    check("len0_done_next_cycle", {62'd0, done, busy}, 64'h2);
    @(negedge clk);
    check("len0_done_one_cycle", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    check("len0_no_write", 64'(cap.size()), 64'd0);
    check("len0_words_written", 64'(words_written), 64'd0);

    // Gapped stream with a stray start during PACK
    clear_obs();
    nacc = 0;
    exp_w[0] = '0;
    exp_w[1] = '0;
    exp_w[2] = '0;
    start_xfer(12'h300, 13'd8);
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h5A + 8'(i * 8'h13));
      exp_w[i/4] = exp_w[i/4] | (32'(b) << (8 * (i % 4)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 5) begin
        cfg_start     = 1'b1;
        cfg_base_addr = 12'h7AA;
        cfg_len_words = 13'd0;
      end
      push_byte(b, (i == 9), 8, ok);
      cfg_start = 1'b0;
      if (ok) nacc++;
    end
    repeat (4) @(negedge clk);
    check("gap_bytes_accepted", 64'(nacc), 64'd10);
    check("gap_num_writes", 64'(cap.size()), 64'd3);
    for (int k = 0; k < 3 && k < cap.size(); k++) begin
      check($sformatf("gap_w%0d_addr", k), 64'(cap[k].a), 64'(12'h300 + 12'(k)));
      check($sformatf("gap_w%0d_din", k), 64'(cap[k].d), 64'(exp_w[k]));
      check($sformatf("gap_w%0d_we", k), 64'(cap[k].we), (k == 2) ? 64'h3 : 64'hF);
    end
    check("gap_words_written", 64'(words_written), 64'd3);
    check("gap_done_pulses", 64'(done_cnt), 64'd1);
    check("gap_err_len", {63'd0, err_len}, 64'd0);

    // Asynchronous reset mid-PACK after two bytes
    clear_obs();
    start_xfer(12'h050, 13'd4);
    push_byte(8'hAB, 1'b0, 8, ok);
    push_byte(8'hCD, 1'b0, 8, ok);
    check("rstmid_busy_before", {62'd0, busy, bus.s_ready}, 64'h3);
    #2;
    rst_b = 1'b0;
    #1;
    check("rstmid_s_ready_ram", {58'd0, bus.s_ready, bus.ram_en, bus.ram_we}, 64'd0);
    check("rstmid_status", {48'd0, busy, done, err_len, words_written}, 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    clear_obs();
    nacc = 0;
    start_xfer(12'h060, 13'd2);
    for (int i = 0; i < 5; i++) begin
      push_byte(8'(i + 1), (i == 4), 8, ok);
      if (ok) nacc++;
    end
    repeat (4) @(negedge clk);
    check("rstmid_next_accepted", 64'(nacc), 64'd5);
    check("rstmid_next_writes", 64'(cap.size()), 64'd2);
    if (cap.size() >= 2) begin
      check("rstmid_w0", 64'(cap[0]), 64'({12'h060, 32'h04030201, 4'hF}));
      check("rstmid_w1", 64'(cap[1]), 64'({12'h061, 32'h00000005, 4'h1}));
    end
    check("rstmid_next_err", {63'd0, err_len}, 64'd0);
    check("rstmid_next_words", 64'(words_written), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
